// File: rtl/salsa_blockmix.sv
`default_nettype none
// ============================================================================
// Module   : salsa / salsa_blockmix
// Brief    : scrypt BlockMix (r=1) sequencer around one feedback-mode Salsa20
//            core; DR double-rounds per pass, one salsa clock per double-round.
// Revision : 1.0 - initial release
// ============================================================================

module salsa (
    input  logic         clk,
    input  logic         feedback,
    input  logic [511:0] B,
    input  logic [511:0] Bx,
    output logic [511:0] Bo
);

    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
        logic [31:0] ta, tb, tc, td;
        tb = b ^ rotl(a + d, 7);
        tc = c ^ rotl(tb + a, 9);
        td = d ^ rotl(tc + tb, 13);
        ta = a ^ rotl(td + tc, 18);
        return {ta, tb, tc, td};
    endfunction

    // One column round followed by one row round.
    function automatic logic [511:0] double_round(input logic [511:0] s);
        logic [31:0]  x [16];
        logic [511:0] o;
        for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
        {x[0],  x[4],  x[8],  x[12]} = qr(x[0],  x[4],  x[8],  x[12]);
        {x[5],  x[9],  x[13], x[1]}  = qr(x[5],  x[9],  x[13], x[1]);
        {x[10], x[14], x[2],  x[6]}  = qr(x[10], x[14], x[2],  x[6]);
        {x[15], x[3],  x[7],  x[11]} = qr(x[15], x[3],  x[7],  x[11]);
        {x[0],  x[1],  x[2],  x[3]}  = qr(x[0],  x[1],  x[2],  x[3]);
        {x[5],  x[6],  x[7],  x[4]}  = qr(x[5],  x[6],  x[7],  x[4]);
        {x[10], x[11], x[8],  x[9]}  = qr(x[10], x[11], x[8],  x[9]);
        {x[15], x[12], x[13], x[14]} = qr(x[15], x[12], x[13], x[14]);
        for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i];
        return o;
    endfunction

    logic [511:0] w_x;
    logic [511:0] w_src;
    logic [511:0] w_dr;
    logic [511:0] r_st;

    assign w_x   = B ^ Bx;
    assign w_src = feedback ? r_st : w_x;
    assign w_dr  = double_round(w_src);

    // Every cycle is overwritten; the first cycle of a pass reloads from w_x.
    always_ff @(posedge clk) begin
        r_st <= w_dr;
    end

    generate
        for (genvar g = 0; g < 16; g++) begin : g_ff
            assign Bo[32*g +: 32] = r_st[32*g +: 32] + w_x[32*g +: 32];
        end
    endgenerate

endmodule

module salsa_blockmix #(
    parameter int DR = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1023:0] X_in,
    output logic          busy,
    output logic          done,
    output logic [1023:0] X_out
);

    localparam int            CW   = $clog2(DR + 1);
    localparam logic [CW-1:0] C_DR = CW'(DR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_H0   = 2'd1,
        S_H1   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [1023:0]   r_xin;
    logic [511:0]    r_y0;
    logic [1023:0]   r_xout;
    logic            r_done;
    logic            w_last;
    logic            w_fb;
    logic [511:0]    w_B;
    logic [511:0]    w_Bx;
    logic [511:0]    w_Bo;

    assign w_last = (r_cnt == C_DR);

    always_comb begin
        w_state_nxt = r_state;
        w_B         = '0;
        w_Bx        = '0;
        w_fb        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_H0;
            end
            S_H0: begin
                w_B  = r_xin[511:0];
                w_Bx = r_xin[1023:512];
                w_fb = (r_cnt != '0);
                if (w_last) w_state_nxt = S_H1;
            end
            S_H1: begin
                w_B  = r_xin[1023:512];
                w_Bx = r_y0;
                w_fb = (r_cnt != '0);
                if (w_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_xin   <= '0;
            r_y0    <= '0;
            r_xout  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_xin <= X_in;
                        r_cnt <= '0;
                    end
                end
                S_H0: begin
                    if (w_last) begin
                        r_y0  <= w_Bo;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_H1: begin
                    if (w_last) begin
                        r_xout <= {w_Bo, r_y0};
                        r_done <= 1'b1;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    salsa u_salsa (
        .clk      (clk),
        .feedback (w_fb),
        .B        (w_B),
        .Bx       (w_Bx),
        .Bo       (w_Bo)
    );

    assign busy  = (r_state != S_IDLE);
    assign done  = r_done;
    assign X_out = r_xout;

endmodule

`default_nettype wire

// File: tb/tb_salsa_blockmix.sv
`default_nettype none
// ============================================================================
// Module   : tb_salsa_blockmix
// Brief    : Self-checking bench for salsa_blockmix (DR=4 and DR=1 instances).
// Revision : 1.0 - initial release
// ============================================================================

module tb_salsa_blockmix;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, start1;
    logic [1023:0] X_in, X_in1;
    logic          busy, busy1, done, done1;
    logic [1023:0] X_out, X_out1;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    salsa_blockmix #(.DR(4)) dut (
        .clk (clk), .reset (reset), .start (start), .X_in (X_in),
        .busy (busy), .done (done), .X_out (X_out)
    );

    salsa_blockmix #(.DR(1)) dut1 (
        .clk (clk), .reset (reset), .start (start1), .X_in (X_in1),
        .busy (busy1), .done (done1), .X_out (X_out1)
    );

    typedef struct {
        logic [1023:0] x;
        logic [1023:0] exp;
    } vec_t;

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Straight Salsa20/(2*drs) core with feed-forward.
    function automatic logic [511:0] salsa_ref(input logic [511:0] inp, input int drs);
        logic [31:0]  x [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) x[i] = inp[32*i +: 32];
        for (int k = 0; k < drs; k++) begin
            x[ 4] ^= rl(x[ 0] + x[12],  7);  x[ 8] ^= rl(x[ 4] + x[ 0],  9);
            x[12] ^= rl(x[ 8] + x[ 4], 13);  x[ 0] ^= rl(x[12] + x[ 8], 18);
            x[ 9] ^= rl(x[ 5] + x[ 1],  7);  x[13] ^= rl(x[ 9] + x[ 5],  9);
            x[ 1] ^= rl(x[13] + x[ 9], 13);  x[ 5] ^= rl(x[ 1] + x[13], 18);
            x[14] ^= rl(x[10] + x[ 6],  7);  x[ 2] ^= rl(x[14] + x[10],  9);
            x[ 6] ^= rl(x[ 2] + x[14], 13);  x[10] ^= rl(x[ 6] + x[ 2], 18);
            x[ 3] ^= rl(x[15] + x[11],  7);  x[ 7] ^= rl(x[ 3] + x[15],  9);
            x[11] ^= rl(x[ 7] + x[ 3], 13);  x[15] ^= rl(x[11] + x[ 7], 18);
            x[ 1] ^= rl(x[ 0] + x[ 3],  7);  x[ 2] ^= rl(x[ 1] + x[ 0],  9);
            x[ 3] ^= rl(x[ 2] + x[ 1], 13);  x[ 0] ^= rl(x[ 3] + x[ 2], 18);
            x[ 6] ^= rl(x[ 5] + x[ 4],  7);  x[ 7] ^= rl(x[ 6] + x[ 5],  9);
            x[ 4] ^= rl(x[ 7] + x[ 6], 13);  x[ 5] ^= rl(x[ 4] + x[ 7], 18);
            x[11] ^= rl(x[10] + x[ 9],  7);  x[ 8] ^= rl(x[11] + x[10],  9);
            x[ 9] ^= rl(x[ 8] + x[11], 13);  x[10] ^= rl(x[ 9] + x[ 8], 18);
            x[12] ^= rl(x[15] + x[14],  7);  x[13] ^= rl(x[12] + x[15],  9);
            x[14] ^= rl(x[13] + x[12], 13);  x[15] ^= rl(x[14] + x[13], 18);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + inp[32*i +: 32];
        return r;
    endfunction

    function automatic logic [1023:0] blockmix_ref(input logic [1023:0] x, input int drs);
        logic [511:0] y0, y1;
        y0 = salsa_ref(x[511:0] ^ x[1023:512], drs);
        y1 = salsa_ref(x[1023:512] ^ y0, drs);
        return {y1, y0};
    endfunction

    function automatic logic [1023:0] rand1024();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        int j;
        n_chk++;
        if (act !== exp) begin
            n_err++;
            j = 0;
            for (int i = 31; i >= 0; i--) if (act[32*i +: 32] !== exp[32*i +: 32]) j = i;
            $display("FAIL %s: word %0d actual %08h required %08h",
                     nm, j, act[32*j +: 32], exp[32*j +: 32]);
        end
    endtask

    task automatic do_op(input logic [1023:0] x, input logic [1023:0] exp, input string nm);
        int           k;
        logic         bz_ok;
        logic [511:0] y0e;
        y0e = salsa_ref(x[511:0] ^ x[1023:512], 4);
        @(negedge clk); start = 1'b1; X_in = x;
        @(negedge clk); start = 1'b0; X_in = rand1024();
        k = 0; bz_ok = 1'b1;
        while (done !== 1'b1 && k < 40) begin
            if (busy !== 1'b1) bz_ok = 1'b0;
            if (k == 5) chk({nm, " y0"}, dut.r_y0, y0e);
            @(negedge clk); k++;
        end
        chk({nm, " busy"}, bz_ok, 1'b1);
        chk({nm, " latency"}, 1024'(k), 1024'(10));
        chk({nm, " busy@done"}, busy, 1'b0);
        chk({nm, " X_out"}, X_out, exp);
        @(negedge clk);
        chk({nm, " done pulse"}, done, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl [6];
        logic [1023:0] x, got, hold;
        logic [1023:0] v [5];
        logic [1023:0] e [5];
        int            ndone, idx, k;
        logic          hold_ok;
        int            want [5];

        reset = 1'b1; start = 1'b0; start1 = 1'b0; X_in = '0; X_in1 = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset X_out", X_out, '0);
        chk("reset X_out1", X_out1, '0);
        reset = 1'b0;

        tbl[0].x = '0;                      tbl[0].exp = '0;
        tbl[1].x = '1;
        tbl[2].x = {32{32'h01234567}};
        tbl[3].x = 1024'h1 << 777;
        tbl[4].x = rand1024();
        tbl[5].x = rand1024();
        for (int i = 1; i < 6; i++) tbl[i].exp = blockmix_ref(tbl[i].x, 4);

        for (int i = 0; i < 6; i++) do_op(tbl[i].x, tbl[i].exp, $sformatf("vec%0d", i));

        for (int i = 0; i < 100; i++) begin
            x = rand1024();
            do_op(x, blockmix_ref(x, 4), $sformatf("rnd%0d", i));
        end

        // Input isolation: X_in churns and start stays high while busy.
        x = rand1024();
        @(negedge clk); start = 1'b1; X_in = x;
        ndone = 0; got = '0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++; got = X_out; start = 1'b0;
            end else begin
                start = busy; X_in = rand1024();
            end
        end
        start = 1'b0;
        chk("iso done count", 1024'(ndone), 1024'(1));
        chk("iso X_out", got, blockmix_ref(x, 4));

        // Back-to-back: restart in each done cycle.
        for (int i = 0; i < 5; i++) begin
            v[i] = rand1024(); e[i] = blockmix_ref(v[i], 4); want[i] = 10 + 11 * i;
        end
        @(negedge clk); start = 1'b1; X_in = v[0];
        idx = 0; k = 0; hold_ok = 1'b1; hold = '0;
        while (idx < 5 && k < 70) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                chk($sformatf("b2b%0d edge", idx), 1024'(k), 1024'(want[idx]));
                chk($sformatf("b2b%0d X_out", idx), X_out, e[idx]);
                hold = X_out;
                idx++;
                if (idx < 5) begin start = 1'b1; X_in = v[idx]; end
            end else if (idx > 0 && X_out !== hold) begin
                hold_ok = 1'b0;
            end
            k++;
        end
        chk("b2b count", 1024'(idx), 1024'(5));
        chk("b2b hold", hold_ok, 1'b1);

        // Reset asserted at E5 of an operation.
        @(negedge clk); @(negedge clk);
        x = rand1024();
        @(negedge clk); start = 1'b1; X_in = x;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rst busy", busy, 1'b0);
        chk("rst X_out", X_out, '0);
        chk("rst done", done, 1'b0);
        ndone = 0;
        repeat (15) begin @(negedge clk); if (done === 1'b1) ndone++; end
        chk("rst no done", 1024'(ndone), 1024'(0));
        x = rand1024();
        do_op(x, blockmix_ref(x, 4), "post-rst");

        // DR=1 instance.
        for (int i = 0; i < 3; i++) begin
            x = (i == 0) ? '0 : rand1024();
            @(negedge clk); start1 = 1'b1; X_in1 = x;
            @(negedge clk); start1 = 1'b0; X_in1 = rand1024();
            k = 0;
            while (done1 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
            chk($sformatf("dr1_%0d latency", i), 1024'(k), 1024'(4));
            chk($sformatf("dr1_%0d X_out", i), X_out1, blockmix_ref(x, 1));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
